clk_div_multi: RTL and testbench

Parametrised multi-channel clock divider for the digital-tube display path. It generates NCH independent derived timebases from clk_50M, such as the scan-multiplex rate, the blink rate and the 1 Hz seconds tick. Each channel has a run-time-programmable divisor, an enable, and a selectable output mode: 50 % square wave or single-cycle strobe. It replaces the fixed single-output divider and feeds the scan and counter logic as clock enables, never as clocks.

---
 rtl/clk_div_pkg.sv | 21 ++
 rtl/clk_div_ch.sv | 126 ++++++++++++
 rtl/clk_div_multi.sv | 61 ++++++
 tb/tb_clk_div_multi.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// ---------------------------------------------------------------------------
// clk_div_pkg
// Shared definitions for the multi-channel clock divider:
//   MODE_TOGGLE / MODE_PULSE : per-channel output mode encodings
//   CW_DEF / DIV_RST_DEF     : default counter width and reset divisor
//   sel_w()                  : width of the channel-select field for n channels
// ---------------------------------------------------------------------------
package clk_div_pkg;

    localparam logic MODE_TOGGLE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int          CW_DEF      = 26;
    localparam int unsigned DIV_RST_DEF = 25_000_000;

    // A single channel still needs a 1-bit select port.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clk_div_ch.sv
// ---------------------------------------------------------------------------
// clk_div_ch
// One divider channel: counter, active (and optionally shadow) divisor,
// toggle level and terminal-count strobe. Every output is a flop.
//
// Optional build macro: CLK_DIV_SYNC_LOAD_EN
//   defined   : writes land in a shadow register and become active at the
//               next terminal count (the current period completes unchanged)
//   undefined : writes replace the active divisor at once and restart the
//               count from zero; the toggle level is kept
//
// Ports:
//   clk_50M  in   system clock
//   reset    in   asynchronous active-low reset
//   en       in   count enable; 0 holds cnt/tog and forces tick low
//   mode     in   0 = toggle (f_out is 50 % square), 1 = pulse (f_out = tick)
//   wr       in   divisor write strobe for this channel
//   div_val  in   divisor value (0 behaves as 1)
//   f_out    out  square wave or strobe, per mode
//   tick     out  one-cycle strobe at each terminal count
// ---------------------------------------------------------------------------
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int          CW      = CW_DEF,
    parameter int unsigned DIV_RST = DIV_RST_DEF
)(
    input  logic          clk_50M,
    input  logic          reset,
    input  logic          en,
    input  logic          mode,
    input  logic          wr,
    input  logic [CW-1:0] div_val,
    output logic          f_out,
    output logic          tick
);

    localparam logic [CW-1:0] DIV_INIT = CW'(DIV_RST);

    // A divisor of zero would never reach terminal count; run it as /1.
    function automatic logic [CW-1:0] sat_div(input logic [CW-1:0] d);
        return (d == '0) ? {{(CW-1){1'b0}}, 1'b1} : d;
    endfunction

    logic [CW-1:0] cnt, cnt_nx;
    logic [CW-1:0] div_act, act_nx;
    logic [CW-1:0] d_last;
    logic          tog, tog_nx;
    logic          tick_r, tick_nx;
    logic          f_out_r;
    logic          term;

`ifdef CLK_DIV_SYNC_LOAD_EN
    logic [CW-1:0] div_shd, shd_nx;
`endif

    // '>=' rather than '==' so that a divisor shrinking below the current
    // count still ends the period on the next edge instead of wrapping.
    always_comb begin
        d_last = sat_div(div_act) - 1'b1;
        term   = (cnt >= d_last);
    end

    always_comb begin
        cnt_nx  = cnt;
        tog_nx  = tog;
        tick_nx = 1'b0;
        act_nx  = div_act;
`ifdef CLK_DIV_SYNC_LOAD_EN
        shd_nx  = div_shd;
`endif
        if (en) begin
            if (term) begin
                cnt_nx  = '0;
                tick_nx = 1'b1;
                tog_nx  = ~tog;
            end else begin
                cnt_nx  = cnt + 1'b1;
            end
        end
`ifdef CLK_DIV_SYNC_LOAD_EN
        if (wr) begin
            shd_nx = div_val;
        end
        // A write arriving on the boundary itself is taken directly.
        if (en && term) begin
            act_nx = wr ? div_val : div_shd;
        end
`else
        // Immediate load: the new period starts from this edge.
        if (wr) begin
            act_nx  = div_val;
            cnt_nx  = '0;
            tick_nx = 1'b0;
            tog_nx  = tog;
        end
`endif
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            tog     <= 1'b0;
            tick_r  <= 1'b0;
            f_out_r <= 1'b0;
            div_act <= DIV_INIT;
`ifdef CLK_DIV_SYNC_LOAD_EN
            div_shd <= DIV_INIT;
`endif
        end else begin
            cnt     <= cnt_nx;
            tog     <= tog_nx;
            tick_r  <= tick_nx;
            div_act <= act_nx;
            // Mode is sampled here so f_out stays a flop output.
            f_out_r <= (mode == MODE_PULSE) ? tick_nx : tog_nx;
`ifdef CLK_DIV_SYNC_LOAD_EN
            div_shd <= shd_nx;
`endif
        end
    end

    assign f_out = f_out_r;
    assign tick  = tick_r;

endmodule

// File: rtl/clk_div_multi.sv
// ---------------------------------------------------------------------------
// clk_div_multi
// NCH independent programmable clock-enable generators for the display path
// (scan multiplex, blink, seconds tick). Outputs are enables, not clocks.
//
// Optional build macro: CLK_DIV_SYNC_LOAD_EN (glitch-free divisor reload at
// terminal count; see clk_div_ch).
//
// Ports:
//   clk_50M  in   50 MHz system clock
//   reset    in   asynchronous active-low reset
//   en       in   [NCH]  per-channel count enable
//   mode     in   [NCH]  per-channel mode: 0 toggle, 1 pulse
//   div_we   in   divisor write strobe (one cycle)
//   div_sel  in   [SW]   target channel; values >= NCH are ignored
//   div_val  in   [CW]   divisor value
//   f_out    out  [NCH]  per-channel square wave or strobe
//   tick     out  [NCH]  per-channel terminal-count strobe
// ---------------------------------------------------------------------------
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NCH     = 2,
    parameter int          CW      = CW_DEF,
    parameter int unsigned DIV_RST = DIV_RST_DEF,
    localparam int         SW      = sel_w(NCH)
)(
    input  logic           clk_50M,
    input  logic           reset,
    input  logic [NCH-1:0] en,
    input  logic [NCH-1:0] mode,
    input  logic           div_we,
    input  logic [SW-1:0]  div_sel,
    input  logic [CW-1:0]  div_val,
    output logic [NCH-1:0] f_out,
    output logic [NCH-1:0] tick
);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr;

        // Matching only indices that exist makes out-of-range selects a
        // no-op without a separate bounds compare.
        assign wr = div_we && (div_sel == SW'(i));

        clk_div_ch #(
            .CW      (CW),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .clk_50M (clk_50M),
            .reset   (reset),
            .en      (en[i]),
            .mode    (mode[i]),
            .wr      (wr),
            .div_val (div_val),
            .f_out   (f_out[i]),
            .tick    (tick[i])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// ---------------------------------------------------------------------------
// tb_clk_div_multi
// Directed bench for clk_div_multi with NCH = 3 (so a 2-bit select can name a
// nonexistent channel), CW = 26, DIV_RST = 5. Channel 2 stays disabled.
// ---------------------------------------------------------------------------
module tb_clk_div_multi;
    import clk_div_pkg::*;

    localparam int NCH = 3;
    localparam int CW  = 26;
    localparam int SW  = 2;

    logic           clk_50M;
    logic           reset;
    logic [NCH-1:0] en;
    logic [NCH-1:0] mode;
    logic           div_we;
    logic [SW-1:0]  div_sel;
    logic [CW-1:0]  div_val;
    logic [NCH-1:0] f_out;
    logic [NCH-1:0] tick;

    clk_div_multi #(
        .NCH     (NCH),
        .CW      (CW),
        .DIV_RST (5)
    ) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .en      (en),
        .mode    (mode),
        .div_we  (div_we),
        .div_sel (div_sel),
        .div_val (div_val),
        .f_out   (f_out),
        .tick    (tick)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    typedef struct {
        int         cyc;
        logic [1:0] ch;
        logic       tick;
        logic       fout;
        bit         chk_f;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_chk;
    int   n_err;

    task automatic chk(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic push(input int c, input int ch, input logic t, input logic f,
                        input bit cf, input string tag);
        exp_t e;
        e.cyc   = c;
        e.ch    = 2'(ch);
        e.tick  = t;
        e.fout  = f;
        e.chk_f = cf;
        e.tag   = tag;
        sb.push_back(e);
    endtask

    // Advance one edge, then compare every expectation due at this edge.
    task automatic step();
        exp_t e;
        @(posedge clk_50M);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            n_chk++;
            assert (e.cyc == cyc && tick[e.ch] === e.tick) else begin
                n_err++;
                $error("FAIL %s tick ch%0d edge%0d: observed=%b expected=%b",
                       e.tag, e.ch, e.cyc, tick[e.ch], e.tick);
            end
            if (e.chk_f) begin
                n_chk++;
                assert (f_out[e.ch] === e.fout) else begin
                    n_err++;
                    $error("FAIL %s f_out ch%0d edge%0d: observed=%b expected=%b",
                           e.tag, e.ch, e.cyc, f_out[e.ch], e.fout);
                end
            end
        end
    endtask

    // Channel 1 after the second release: pulse mode, D = 3 written at edge 1.
    function automatic logic ch1_tick(input int k);
`ifdef CLK_DIV_SYNC_LOAD_EN
        return (k >= 5) && ((k - 5) % 3 == 0);
`else
        return (k >= 4) && ((k - 1) % 3 == 0);
`endif
    endfunction

    // Channel 0 after the second release: D = 5, en low for edges 18..24,
    // D = 2 written at edge 29, D = 0 written at edge 41. Returns {tick, f_out}.
    function automatic logic [1:0] ch0_exp(input int k);
        logic t, f;
        if (k <= 17) begin
            t = (k % 5 == 0);
            f = ((k / 5) % 2 == 1);
        end else if (k <= 26) begin
            t = 1'b0;
            f = 1'b1;
        end else if (k == 27) begin
            t = 1'b1;
            f = 1'b0;
        end else if (k <= 40) begin
`ifdef CLK_DIV_SYNC_LOAD_EN
            if (k < 32) begin
                t = 1'b0;
                f = 1'b0;
            end else begin
                t = ((k - 32) % 2 == 0);
                f = ((((k - 32) / 2) + 1) % 2 == 1);
            end
`else
            if (k < 30) begin
                t = 1'b0;
                f = 1'b0;
            end else begin
                t = ((k - 29) % 2 == 0);
                f = (((k - 29) / 2) % 2 == 1);
            end
`endif
        end else begin
            t = (k >= 42);
            f = 1'b0;
        end
        return {t, f};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] e0;
        logic       t1;

        reset   = 1'b0;
        en      = '0;
        mode    = '0;
        div_we  = 1'b0;
        div_sel = '0;
        div_val = '0;
        cyc     = 0;
        n_chk   = 0;
        n_err   = 0;

        // Held in reset with channels enabled: outputs stay low.
        en = 3'b011;
        repeat (3) @(posedge clk_50M);
        #1;
        chk("reset_tick", tick, '0);
        chk("reset_fout", f_out, '0);

        // First release, both active channels toggle mode with D = 5.
        for (int k = 1; k <= 17; k++) begin
            push(k, 0, (k % 5 == 0), ((k / 5) % 2 == 1), 1'b1, "rel1_ch0");
            push(k, 1, (k % 5 == 0), ((k / 5) % 2 == 1), 1'b1, "rel1_ch1");
            push(k, 2, 1'b0, 1'b0, 1'b1, "rel1_ch2");
        end
        @(negedge clk_50M);
        reset = 1'b1;
        cyc   = 0;
        repeat (17) step();

        // Mid-period reset while f_out[1:0] are high: must clear without an edge.
        @(negedge clk_50M);
        reset = 1'b0;
        #1;
        chk("async_reset_tick", tick, '0);
        chk("async_reset_fout", f_out, '0);
        repeat (2) @(posedge clk_50M);
        #1;
        chk("reset_held_fout", f_out, '0);

        // Second release: full directed sequence.
        for (int k = 1; k <= 60; k++) begin
            e0 = ch0_exp(k);
            t1 = ch1_tick(k);
            push(k, 0, e0[1], e0[0], (k <= 40), "rel2_ch0");
            push(k, 1, t1, t1, 1'b1, "rel2_ch1");
            push(k, 2, 1'b0, 1'b0, 1'b1, "rel2_ch2");
        end
        mode = 3'b010;
        @(negedge clk_50M);
        reset   = 1'b1;
        cyc     = 0;
        div_we  = 1'b1;
        div_sel = 2'd1;
        div_val = 26'd3;
        step();                         // edge 1: ch1 divisor write
        div_we = 1'b0;
        repeat (16) step();             // edges 2..17
        en[0] = 1'b0;
        repeat (7) step();              // edges 18..24: ch0 held at cnt = 2
        en[0] = 1'b1;
        repeat (4) step();              // edges 25..28
        div_we  = 1'b1;
        div_sel = 2'd0;
        div_val = 26'd2;
        step();                         // edge 29: ch0 D = 2 at cnt = 1
        div_we = 1'b0;
        repeat (11) step();             // edges 30..40
        div_we  = 1'b1;
        div_sel = 2'd0;
        div_val = 26'd0;
        step();                         // edge 41: ch0 D = 0
        div_we = 1'b0;
        repeat (9) step();              // edges 42..50
        div_we  = 1'b1;
        div_sel = 2'd3;
        div_val = 26'd1;
        step();                         // edge 51: select beyond NCH
        div_we = 1'b0;
        repeat (9) step();              // edges 52..60

        n_chk++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: observed=%0d pending expected=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
